// File: rtl/synth_voice_pkg.sv
// Shared types for the polyphonic voice allocator.
// Slot states, scheduler states and small helpers.
package synth_voice_pkg;

  typedef enum logic [1:0] {
    VS_IDLE,
    VS_GATED,
    VS_REL
  } vstate_e;

  typedef enum logic [1:0] {
    AS_IDLE,
    AS_SCAN,
    AS_COMMIT
  } astate_e;

  localparam int NULL_CODE  = 0;
  localparam int MAX_VOICES = 8;

  function automatic logic [3:0] popcnt8(
    input logic [MAX_VOICES-1:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_VOICES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/voice_lru_rank.sv
// Allocation-age ranks per voice slot.
// Rank 0 is the most recently allocated slot.
module voice_lru_rank #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 touch_i,
  input  logic [IW-1:0]        idx_i,
  output logic [N-1:0][IW-1:0] rank_o
);

  logic [N-1:0][IW-1:0] rank_q;
  logic [N-1:0][IW-1:0] rank_d;
  logic [IW-1:0]        old;

  always_comb begin
    old    = rank_q[idx_i];
    rank_d = rank_q;
    if (touch_i) begin
      for (int j = 0; j < N; j++) begin
        if (IW'(j) == idx_i) begin
          rank_d[j] = '0;
        end else if (rank_q[j] < old) begin
          rank_d[j] = rank_q[j] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int j = 0; j < N; j++) begin
        rank_q[j] <= IW'(j);
      end
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank_o = rank_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note events to voice slots,
// with a serial per-slot scan followed by a single commit cycle.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int CODE_W     = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [CODE_W-1:0]            ev_code,
  input  logic [NUM_VOICES-1:0]        release_done,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic [NUM_VOICES*CODE_W-1:0] voice_code,
  output logic [3:0]                   voice_count,
  output logic                         steal_pulse,
  output logic                         done_pulse
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef struct packed {
    logic          gm_v;
    logic [IW-1:0] gm_i;
    logic          rm_v;
    logic [IW-1:0] rm_i;
    logic          il_v;
    logic [IW-1:0] il_i;
    logic          rr_v;
    logic [IW-1:0] rr_i;
    logic [IW-1:0] rr_r;
    logic          gr_v;
    logic [IW-1:0] gr_i;
    logic [IW-1:0] gr_r;
  } scan_t;

  astate_e st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic on_q, on_d;
  logic [CODE_W-1:0] evc_q, evc_d;
  scan_t scan_q, scan_d;
  vstate_e vs_q [NUM_VOICES];
  vstate_e vs_d [NUM_VOICES];
  logic [CODE_W-1:0] code_q [NUM_VOICES];
  logic [CODE_W-1:0] code_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_d;
  logic [3:0] cnt_q;
  logic done_q, done_d;
  logic steal_q, steal_d;
  logic touch;
  logic [IW-1:0] sel;
  logic [NUM_VOICES-1:0][IW-1:0] rank;
  vstate_e cur;
  logic [IW-1:0] rk;
  logic hit;

  voice_lru_rank #(
    .N  (NUM_VOICES),
    .IW (IW)
  ) u_lru (
    .clk_i   (CLOCK_50),
    .rst_ni  (resetn),
    .touch_i (touch),
    .idx_i   (sel),
    .rank_o  (rank)
  );

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    on_d    = on_q;
    evc_d   = evc_q;
    scan_d  = scan_q;
    vs_d    = vs_q;
    code_d  = code_q;
    done_d  = 1'b0;
    steal_d = 1'b0;
    touch   = 1'b0;
    sel     = '0;
    cur     = vs_q[idx_q];
    rk      = rank[idx_q];
    hit     = (code_q[idx_q] == evc_q);

    // Releases land first so a same-edge commit overrides them.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (release_done[i] && vs_q[i] == VS_REL) begin
        vs_d[i]   = VS_IDLE;
        code_d[i] = '0;
      end
    end

    unique case (st_q)
      AS_IDLE: begin
        if (ev_valid && ev_code != CODE_W'(NULL_CODE)) begin
          st_d   = AS_SCAN;
          idx_d  = '0;
          on_d   = ev_on;
          evc_d  = ev_code;
          scan_d = '0;
        end
      end
      AS_SCAN: begin
        unique case (cur)
          VS_GATED: begin
            if (hit && !scan_q.gm_v) begin
              scan_d.gm_v = 1'b1;
              scan_d.gm_i = idx_q;
            end
            if (!scan_q.gr_v || rk > scan_q.gr_r) begin
              scan_d.gr_v = 1'b1;
              scan_d.gr_i = idx_q;
              scan_d.gr_r = rk;
            end
          end
          VS_REL: begin
            if (hit && !scan_q.rm_v) begin
              scan_d.rm_v = 1'b1;
              scan_d.rm_i = idx_q;
            end
            if (!scan_q.rr_v || rk > scan_q.rr_r) begin
              scan_d.rr_v = 1'b1;
              scan_d.rr_i = idx_q;
              scan_d.rr_r = rk;
            end
          end
          default: begin
            if (!scan_q.il_v) begin
              scan_d.il_v = 1'b1;
              scan_d.il_i = idx_q;
            end
          end
        endcase
        if (idx_q == LAST) begin
          st_d = AS_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      AS_COMMIT: begin
        st_d   = AS_IDLE;
        done_d = 1'b1;
        if (on_q) begin
          if (!scan_q.gm_v) begin
            touch = 1'b1;
            if (scan_q.rm_v) begin
              sel = scan_q.rm_i;
            end else if (scan_q.il_v) begin
              sel = scan_q.il_i;
            end else if (scan_q.rr_v) begin
              sel     = scan_q.rr_i;
              steal_d = 1'b1;
            end else begin
              sel     = scan_q.gr_i;
              steal_d = 1'b1;
            end
            vs_d[sel]   = VS_GATED;
            code_d[sel] = evc_q;
          end
        end else if (scan_q.gm_v) begin
          vs_d[scan_q.gm_i] = VS_REL;
        end
      end
      default: st_d = AS_IDLE;
    endcase

    for (int i = 0; i < NUM_VOICES; i++) begin
      gate_d[i] = (vs_d[i] == VS_GATED);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      st_q    <= AS_IDLE;
      idx_q   <= '0;
      on_q    <= 1'b0;
      evc_q   <= '0;
      scan_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      steal_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vs_q[i]   <= VS_IDLE;
        code_q[i] <= '0;
      end
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      evc_q   <= evc_d;
      scan_q  <= scan_d;
      cnt_q   <= popcnt8(MAX_VOICES'(gate_d));
      done_q  <= done_d;
      steal_q <= steal_d;
      vs_q    <= vs_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    voice_code = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_gate[i] = (vs_q[i] == VS_GATED);
      voice_busy[i] = (vs_q[i] != VS_IDLE);
      voice_code[i*CODE_W +: CODE_W] = code_q[i];
    end
  end

  assign ev_ready    = (st_q == AS_IDLE);
  assign voice_count = cnt_q;
  assign done_pulse  = done_q;
  assign steal_pulse = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed table, corner sequences,
// and random events against a queue-based allocation model.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_on = 1'b0;
  logic [7:0] ev_code = '0;
  logic [3:0] release_done = '0;
  logic       ev_ready;
  logic [3:0] voice_gate;
  logic [3:0] voice_busy;
  logic [31:0] voice_code;
  logic [3:0] voice_count;
  logic       steal_pulse;
  logic       done_pulse;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (4),
    .CODE_W     (8)
  ) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_code      (ev_code),
    .release_done (release_done),
    .voice_gate   (voice_gate),
    .voice_busy   (voice_busy),
    .voice_code   (voice_code),
    .voice_count  (voice_count),
    .steal_pulse  (steal_pulse),
    .done_pulse   (done_pulse)
  );

  // Reference model: slot states (0 idle, 1 gated, 2 rel) and an
  // allocation-order queue, most recent first.
  int         m_st [4];
  logic [7:0] m_cd [4];
  int         ord [$];

  typedef struct {
    int         kind;
    bit         on;
    logic [7:0] code;
    logic [3:0] rel;
    logic [3:0] g;
    logic [3:0] b;
    bit         st;
    int         sl;
    logic [7:0] sc;
  } vec_t;

  vec_t tv [15];
  logic [7:0] pool [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0;
      m_cd[i] = '0;
    end
    ord = {0, 1, 2, 3};
  endfunction

  function automatic void m_rel(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && m_st[i] == 2) begin
        m_st[i] = 0;
        m_cd[i] = '0;
      end
    end
  endfunction

  function automatic bit m_event(input bit on, input logic [7:0] c);
    int pick = -1;
    bit stl = 0;
    if (c == 8'h00) return 0;
    if (!on) begin
      for (int i = 0; i < 4; i++) begin
        if (pick < 0 && m_st[i] == 1 && m_cd[i] == c) pick = i;
      end
      if (pick >= 0) m_st[pick] = 2;
      return 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_st[i] == 1 && m_cd[i] == c) return 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (pick < 0 && m_st[i] == 2 && m_cd[i] == c) pick = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (pick < 0 && m_st[i] == 0) pick = i;
    end
    for (int k = ord.size() - 1; k >= 0; k--) begin
      if (pick < 0 && m_st[ord[k]] == 2) begin
        pick = ord[k];
        stl = 1;
      end
    end
    for (int k = ord.size() - 1; k >= 0; k--) begin
      if (pick < 0 && m_st[ord[k]] == 1) begin
        pick = ord[k];
        stl = 1;
      end
    end
    m_st[pick] = 1;
    m_cd[pick] = c;
    for (int k = 0; k < ord.size(); k++) begin
      if (ord[k] == pick) begin
        ord.delete(k);
        break;
      end
    end
    ord.push_front(pick);
    return stl;
  endfunction

  task automatic compare_all(input string tag);
    logic [3:0]  eg;
    logic [3:0]  eb;
    logic [31:0] ec;
    for (int i = 0; i < 4; i++) begin
      eg[i] = (m_st[i] == 1);
      eb[i] = (m_st[i] != 0);
      ec[i*8 +: 8] = m_cd[i];
    end
    chk({tag, "_gate"}, voice_gate, eg);
    chk({tag, "_busy"}, voice_busy, eb);
    chk({tag, "_code"}, voice_code, ec);
    chk({tag, "_count"}, voice_count, $countones(eg));
  endtask

  // Starts and ends on a falling edge; lat counts edges from accept.
  task automatic do_event(input bit on, input logic [7:0] c,
                          output int lat, output bit stl);
    chk("rdy_idle", ev_ready, 1);
    ev_valid = 1'b1;
    ev_on = on;
    ev_code = c;
    @(negedge clk);
    ev_valid = 1'b0;
    lat = 99;
    stl = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_pulse) begin
        lat = k;
        stl = steal_pulse;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rel_pulse(input logic [3:0] mask);
    release_done = mask;
    @(negedge clk);
    release_done = '0;
  endtask

  task automatic ev_chk(input bit on, input logic [7:0] c);
    int lat;
    bit stl;
    bit ms;
    ms = m_event(on, c);
    do_event(on, c, lat, stl);
    chk("ev_lat", lat, (c == 8'h00) ? 99 : 5);
    chk("ev_steal", stl, ms);
    compare_all("ev");
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit stl;
    bit on;
    logic [3:0] mask;
    logic [7:0] c;

    tv[0]  = '{0, 1, 8'h1C, 4'h0, 4'b0001, 4'b0001, 0, 0, 8'h1C};
    tv[1]  = '{0, 1, 8'h1B, 4'h0, 4'b0011, 4'b0011, 0, 1, 8'h1B};
    tv[2]  = '{0, 1, 8'h23, 4'h0, 4'b0111, 4'b0111, 0, 2, 8'h23};
    tv[3]  = '{0, 1, 8'h2B, 4'h0, 4'b1111, 4'b1111, 0, 3, 8'h2B};
    tv[4]  = '{0, 1, 8'h34, 4'h0, 4'b1111, 4'b1111, 1, 0, 8'h34};
    tv[5]  = '{0, 0, 8'h23, 4'h0, 4'b1011, 4'b1111, 0, 2, 8'h23};
    tv[6]  = '{0, 1, 8'h3B, 4'h0, 4'b1111, 4'b1111, 1, 2, 8'h3B};
    tv[7]  = '{0, 0, 8'h34, 4'h0, 4'b1110, 4'b1111, 0, 0, 8'h34};
    tv[8]  = '{0, 1, 8'h34, 4'h0, 4'b1111, 4'b1111, 0, 3, 8'h2B};
    tv[9]  = '{0, 0, 8'h34, 4'h0, 4'b1110, 4'b1111, 0, 0, 8'h34};
    tv[10] = '{1, 0, 8'h00, 4'b0001, 4'b1110, 4'b1110, 0, 0, 8'h00};
    tv[11] = '{0, 0, 8'h4B, 4'h0, 4'b1110, 4'b1110, 0, 0, 8'h00};
    tv[12] = '{0, 1, 8'h1B, 4'h0, 4'b1110, 4'b1110, 0, 1, 8'h1B};
    tv[13] = '{0, 1, 8'h1C, 4'h0, 4'b1111, 4'b1111, 0, 0, 8'h1C};
    tv[14] = '{1, 0, 8'h00, 4'b0010, 4'b1111, 4'b1111, 0, 1, 8'h1B};

    pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'h23; pool[3] = 8'h2B;
    pool[4] = 8'h34; pool[5] = 8'h33; pool[6] = 8'h3B; pool[7] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ev_ready, 1);
    chk("rst_gate", voice_gate, 0);
    chk("rst_busy", voice_busy, 0);
    chk("rst_code", voice_code, 0);
    chk("rst_count", voice_count, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_steal", steal_pulse, 0);
    resetn = 1'b1;
    m_reset();

    // Directed table
    for (int t = 0; t < 15; t++) begin
      if (tv[t].kind == 0) begin
        do_event(tv[t].on, tv[t].code, lat, stl);
        chk($sformatf("tv%0d_lat", t), lat, 5);
        chk($sformatf("tv%0d_steal", t), stl, tv[t].st);
      end else begin
        rel_pulse(tv[t].rel);
      end
      chk($sformatf("tv%0d_gate", t), voice_gate, tv[t].g);
      chk($sformatf("tv%0d_busy", t), voice_busy, tv[t].b);
      chk($sformatf("tv%0d_count", t), voice_count, $countones(tv[t].g));
      chk($sformatf("tv%0d_code", t), voice_code[tv[t].sl*8 +: 8], tv[t].sc);
    end

    // Release pulse lands while a note-off for an unheld key is scanning
    do_reset();
    do_event(1, 8'h1C, lat, stl);
    do_event(0, 8'h1C, lat, stl);
    do_event(1, 8'h2B, lat, stl);
    ev_valid = 1'b1;
    ev_on = 1'b0;
    ev_code = 8'h4B;
    @(negedge clk);
    ev_valid = 1'b0;
    chk("scan_ready", ev_ready, 0);
    release_done = 4'b0001;
    @(negedge clk);
    release_done = '0;
    chk("scan_rel_busy", voice_busy, 4'b0010);
    chk("scan_rel_code", voice_code[7:0], 8'h00);
    lat = 99;
    for (int k = 1; k < 10; k++) begin
      if (done_pulse) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("scan_rel_lat", lat, 5);
    chk("scan_rel_gate", voice_gate, 4'b0010);

    // Retrigger commit coincides with release_done of the same slot
    do_event(1, 8'h1C, lat, stl);
    do_event(0, 8'h1C, lat, stl);
    chk("conf_pre_gate", voice_gate, 4'b0010);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_code = 8'h1C;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("conf_pre_done", done_pulse, 0);
    release_done = 4'b0001;
    @(negedge clk);
    release_done = '0;
    chk("conf_done", done_pulse, 1);
    chk("conf_steal", steal_pulse, 0);
    chk("conf_gate", voice_gate, 4'b0011);
    chk("conf_busy", voice_busy, 4'b0011);
    chk("conf_code0", voice_code[7:0], 8'h1C);
    chk("conf_count", voice_count, 2);

    // Null scan code is swallowed without done_pulse
    do_event(1, 8'h00, lat, stl);
    chk("null_lat", lat, 99);
    chk("null_gate", voice_gate, 4'b0011);
    chk("null_ready", ev_ready, 1);

    // Reset asserted mid-scan
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_code = 8'h44;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", ev_ready, 1);
    chk("mid_rst_gate", voice_gate, 0);
    chk("mid_rst_busy", voice_busy, 0);
    chk("mid_rst_code", voice_code, 0);
    chk("mid_rst_count", voice_count, 0);
    chk("mid_rst_done", done_pulse, 0);
    resetn = 1'b1;
    m_reset();
    repeat (3) ev_chk(1, 8'h1C);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        mask = 4'($urandom_range(1, 15));
        m_rel(mask);
        rel_pulse(mask);
        compare_all("rnd_rel");
      end else begin
        on = ($urandom_range(0, 2) != 0);
        c = pool[$urandom_range(0, 7)];
        ev_chk(on, c);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the PS/2 make/break decoder and the per-voice waveform/envelope datapath.
- Accepts note-on/note-off events carrying a key scan code and assigns each note to one of NUM_VOICES voice slots.
- Tracks each slot through idle, gated and releasing states; steals the least-recently-allocated slot when all slots are busy.
- Drives per-voice gate and scan-code outputs; the key-to-ticks conversion and envelope generators consume them.

Parameters:
NUM_VOICES, 4, number of voice slots (legal 2..8)
CODE_W, 8, scan-code width

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  synchronous active-low reset
ev_valid  in  1  event present
ev_ready  out  1  block accepts event this cycle
ev_on  in  1  1 = make (note-on), 0 = break (note-off)
ev_code  in  CODE_W  key scan code
release_done  in  NUM_VOICES  per-voice one-cycle pulse from envelope: level reached 0
voice_gate  out  NUM_VOICES  per-voice gate to envelope
voice_busy  out  NUM_VOICES  slot gated or releasing
voice_code  out  NUM_VOICES*CODE_W  per-voice scan code, slot i at [i*CODE_W +: CODE_W]
voice_count  out  4  number of gated slots
steal_pulse  out  1  one-cycle pulse when a busy slot was stolen
done_pulse  out  1  one-cycle pulse when an event finishes processing

Behaviour:
- Reset when resetn=0 at a CLOCK_50 edge, including mid-scan:
  - the event in flight is dropped;
  - outputs: gate=0, busy=0, codes=0, voice_count=0, pulses=0, ev_ready=1;
  - FSM returns to IDLE; LRU ranks reset to rank[i]=i.
- Slot state per voice: IDLE (busy=0), GATED (gate=1, busy=1), REL (gate=0, busy=1).
- FSM states:
  - IDLE: ev_ready=1. An event is latched when ev_valid&&ev_ready → SCAN, idx=0. ev_code==0 is discarded with no done_pulse.
  - SCAN: ev_ready=0. Inspects slot idx once per cycle, idx=0..NUM_VOICES-1, then → COMMIT. Records:
    - gated slot whose code matches;
    - REL slot whose code matches;
    - lowest-index IDLE slot;
    - REL slot with highest rank;
    - GATED slot with highest rank.
  - COMMIT: one cycle. Applies the decision, pulses done_pulse, → IDLE.
- Latency: accept → done_pulse = NUM_VOICES+1 cycles. Outputs update on the same edge as done_pulse. Next event is accepted the cycle after.
- Note-on decision, first match wins:
  1. Matching gated slot: no change (absorbs typematic repeats).
  2. Matching REL slot: retrigger it; gate=1.
  3. Lowest-index IDLE slot.
  4. Highest-rank REL slot (steal).
  5. Highest-rank GATED slot (steal).
  - The chosen slot gets code=ev_code and state GATED.
  - Cases 4 and 5 pulse steal_pulse with done_pulse.
  - Any allocation or retrigger moves the chosen slot to rank 0; every slot with rank below its old rank increments by 1. Ranks remain a permutation of 0..NUM_VOICES-1.
- Note-off: a matching gated slot → REL, code retained. No matching gated slot → no change; done_pulse still fires.
- release_done[i] while slot i is REL → IDLE, code cleared to 0, same cycle as the pulse, in any FSM state. Ignored for GATED or IDLE slots.
- Conflict rule: release_done[i] on the same edge as a COMMIT that writes slot i → the COMMIT wins and the slot stays GATED.
- voice_count is registered and equals popcount(voice_gate) after every update.
- Duplicate codes: at most one GATED slot per code is guaranteed by rule 1.

Decomposition:
- Package synth_voice_pkg:
  - slot-state enum {VS_IDLE, VS_GATED, VS_REL};
  - FSM enum {AS_IDLE, AS_SCAN, AS_COMMIT};
  - NULL_CODE = 0;
  - MAX_VOICES = 8.
- Sub-module voice_lru_rank: holds the rank array. Inputs: touch strobe and index. Output: per-slot rank. Rank-update logic is isolated there.

Test Plan:
1. Reset, then on 0x1C → slot0 gated, code 0x1C, voice_count=1, done_pulse 5 cycles after accept (NUM_VOICES=4).
2. Ons 0x1C, 0x1B, 0x23, 0x2B, 0x34 → slots 0–3 filled; 0x34 steals slot0 (oldest gated), steal_pulse=1, voice_count=4.
3. On 0x1C, off 0x1C, on 0x1C before release_done → same slot 0 retriggered, gate back to 1, no steal, other slots untouched.
4. Off 0x1C, then release_done[0] pulse → busy[0]=0, code0=0; off for unheld code 0x4B → done_pulse, no state change.
5. Four held notes, slot2 released (REL), on 0x3B → slot2 reused (REL preferred over gated steal), steal_pulse=1.
6. resetn=0 during SCAN → next edge all outputs 0, ev_ready=1; repeated on 0x1C (typematic) → voice_count stays 1.
